// File: rtl/local_predictor_param.sv
// Two-level local branch predictor: a per-PC history table selects a saturating counter.
// Tables are swept to their initial values by hardware after reset or clear.
module local_predictor_param #(
  parameter int unsigned BHT_IDX_BITS = 8,
  parameter int unsigned HIST_BITS    = 2,
  parameter int unsigned PHT_IDX_BITS = 8,
  parameter int unsigned CTR_BITS     = 2,
  parameter int unsigned STAT_BITS    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  output logic                 ready,
  input  logic [31:0]          read_pc,
  output logic                 prediction,
  input  logic [31:0]          write_pc,
  input  logic                 write,
  input  logic                 write_value,
  output logic                 is_correct,
  output logic [STAT_BITS-1:0] update_count,
  output logic [STAT_BITS-1:0] mispredict_count
);

  localparam int unsigned BhtEntries = 1 << BHT_IDX_BITS;
  localparam int unsigned PhtEntries = 1 << PHT_IDX_BITS;
  localparam int unsigned MaxIdxBits = (BHT_IDX_BITS > PHT_IDX_BITS) ? BHT_IDX_BITS : PHT_IDX_BITS;
  localparam int unsigned SweepLen   = 1 << MaxIdxBits;
  // One spare bit so the table sizes themselves are representable in comparisons.
  localparam int unsigned IdxW       = MaxIdxBits + 1;
  localparam int unsigned PcHiBits   = PHT_IDX_BITS - HIST_BITS;
  localparam logic [CTR_BITS-1:0] CtrInit = {1'b1, {(CTR_BITS - 1) {1'b0}}};

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [STAT_BITS-1:0]   upd_q, upd_d;
  logic [STAT_BITS-1:0]   mis_q, mis_d;

  logic [HIST_BITS-1:0]   bht_q [BhtEntries];
  logic [CTR_BITS-1:0]    pht_q [PhtEntries];

  logic [BHT_IDX_BITS-1:0] r_bht, w_bht;
  logic [HIST_BITS-1:0]    r_hist, w_hist, w_hist_next;
  logic [PHT_IDX_BITS-1:0] r_pht, w_pht;
  logic [CTR_BITS-1:0]     r_ctr, w_ctr, w_ctr_next;
  logic                    accept;
  logic                    unused_pc_bits;

  assign unused_pc_bits = ^{read_pc, write_pc};

  // Read and write paths index the tables independently.
  assign r_bht  = read_pc[BHT_IDX_BITS+1:2];
  assign r_hist = bht_q[r_bht];
  assign r_pht  = {read_pc[PcHiBits+1:2], r_hist};
  assign r_ctr  = pht_q[r_pht];

  assign w_bht  = write_pc[BHT_IDX_BITS+1:2];
  assign w_hist = bht_q[w_bht];
  assign w_pht  = {write_pc[PcHiBits+1:2], w_hist};
  assign w_ctr  = pht_q[w_pht];

  assign ready      = (state_q == StRun);
  assign prediction = ready ? r_ctr[CTR_BITS-1] : 1'b1;
  assign is_correct = ready ? (write_value == w_ctr[CTR_BITS-1]) : write_value;
  assign accept     = write && ready && !clear;

  // Newest outcome enters at the MSB.
  assign w_hist_next = {write_value, w_hist} >> 1;

  always_comb begin
    w_ctr_next = w_ctr;
    if (write_value && (w_ctr != {CTR_BITS{1'b1}})) begin
      w_ctr_next = w_ctr + CTR_BITS'(1);
    end else if (!write_value && (w_ctr != '0)) begin
      w_ctr_next = w_ctr - CTR_BITS'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    upd_d   = upd_q;
    mis_d   = mis_q;
    if (clear) begin
      state_d = StInit;
      idx_d   = '0;
      upd_d   = '0;
      mis_d   = '0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (idx_q == IdxW'(SweepLen - 1)) begin
            state_d = StRun;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
        StRun: begin
          if (accept) begin
            if (upd_q != {STAT_BITS{1'b1}}) upd_d = upd_q + STAT_BITS'(1);
            if (!is_correct && (mis_q != {STAT_BITS{1'b1}})) mis_d = mis_q + STAT_BITS'(1);
          end
        end
        default: state_d = StInit;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      idx_q   <= '0;
      upd_q   <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      upd_q   <= upd_d;
      mis_q   <= mis_d;
    end
  end

  // Table storage has no reset; the sweep provides defined contents.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      if (idx_q < IdxW'(BhtEntries)) bht_q[idx_q[BHT_IDX_BITS-1:0]] <= '0;
      if (idx_q < IdxW'(PhtEntries)) pht_q[idx_q[PHT_IDX_BITS-1:0]] <= CtrInit;
    end else if (accept) begin
      bht_q[w_bht] <= w_hist_next;
      pht_q[w_pht] <= w_ctr_next;
    end
  end

  assign update_count     = upd_q;
  assign mispredict_count = mis_q;

endmodule

// File: tb/tb_local_predictor_param.sv
// Directed bench for local_predictor_param: sweep timing, training, clear, reset and
// statistics saturation on a second narrow-stats instance.
module tb_local_predictor_param;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        ready;
  logic [31:0] read_pc;
  logic        prediction;
  logic [31:0] write_pc;
  logic        write;
  logic        write_value;
  logic        is_correct;
  logic [15:0] update_count;
  logic [15:0] mispredict_count;

  logic        ready2;
  logic        prediction2;
  logic [31:0] write_pc2;
  logic        write2;
  logic        write_value2;
  logic        is_correct2;
  logic [3:0]  update_count2;
  logic [3:0]  mispredict_count2;

  int tests;
  int fails;

  local_predictor_param dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear            (clear),
    .ready            (ready),
    .read_pc          (read_pc),
    .prediction       (prediction),
    .write_pc         (write_pc),
    .write            (write),
    .write_value      (write_value),
    .is_correct       (is_correct),
    .update_count     (update_count),
    .mispredict_count (mispredict_count)
  );

  local_predictor_param #(
    .STAT_BITS (4)
  ) dut_sat (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear            (1'b0),
    .ready            (ready2),
    .read_pc          (32'h0),
    .prediction       (prediction2),
    .write_pc         (write_pc2),
    .write            (write2),
    .write_value      (write_value2),
    .is_correct       (is_correct2),
    .update_count     (update_count2),
    .mispredict_count (mispredict_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Counts clock edges until ready rises, bounded.
  task automatic wait_ready(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (!ready && n < 1000) begin
      if (n == 10) check({name, "_pred_default"}, 32'(prediction), 32'd1);
      @(posedge clk);
      #1;
      n++;
    end
    check(name, n, exp_cycles);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        wv;
    logic        pred_before;
    logic        corr;
    logic        pred_after;
    int          upd;
    int          mis;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{pc: 32'h100, wv: 1'b1, pred_before: 1'b1, corr: 1'b1, pred_after: 1'b1, upd: 1, mis: 0};
    vecs[1] = '{pc: 32'h100, wv: 1'b1, pred_before: 1'b1, corr: 1'b1, pred_after: 1'b1, upd: 2, mis: 0};
    vecs[2] = '{pc: 32'h204, wv: 1'b0, pred_before: 1'b1, corr: 1'b0, pred_after: 1'b0, upd: 3, mis: 1};
    vecs[3] = '{pc: 32'h204, wv: 1'b0, pred_before: 1'b0, corr: 1'b1, pred_after: 1'b0, upd: 4, mis: 1};
    vecs[4] = '{pc: 32'h204, wv: 1'b0, pred_before: 1'b0, corr: 1'b1, pred_after: 1'b0, upd: 5, mis: 1};

    tests        = 0;
    fails        = 0;
    rst_n        = 1'b0;
    clear        = 1'b0;
    read_pc      = 32'h100;
    write_pc     = 32'h0;
    write        = 1'b0;
    write_value  = 1'b1;
    write_pc2    = 32'h0;
    write2       = 1'b0;
    write_value2 = 1'b0;

    // Reset state and first sweep
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_upd", 32'(update_count), 32'd0);
    check("rst_mis", 32'(mispredict_count), 32'd0);
    check("rst_pred", 32'(prediction), 32'd1);
    check("rst_corr_follows_wv", 32'(is_correct), 32'd1);
    rst_n = 1'b1;
    wait_ready("init_sweep_len", 256);
    check("ready2", 32'(ready2), 32'd1);
    #1;
    check("post_init_pred_100", 32'(prediction), 32'd1);
    read_pc = 32'h204;
    #1;
    check("post_init_pred_204", 32'(prediction), 32'd1);

    // Saturating statistics: fresh entries predict taken, so not-taken always mispredicts
    @(posedge clk);
    #1;
    for (int k = 0; k < 20; k++) begin
      write_pc2    = 32'(4 * k);
      write2       = 1'b1;
      write_value2 = 1'b0;
      #1;
      check("sat_corr", 32'(is_correct2), 32'd0);
      @(posedge clk);
      #1;
    end
    write2 = 1'b0;
    #1;
    check("sat_upd", 32'(update_count2), 32'd15);
    check("sat_mis", 32'(mispredict_count2), 32'd15);

    // Training table, read and write on the same PC
    for (int i = 0; i < 5; i++) begin
      read_pc     = vecs[i].pc;
      write_pc    = vecs[i].pc;
      write_value = vecs[i].wv;
      write       = 1'b1;
      #1;
      check($sformatf("v%0d_pred_before", i), 32'(prediction), 32'(vecs[i].pred_before));
      check($sformatf("v%0d_corr", i), 32'(is_correct), 32'(vecs[i].corr));
      @(posedge clk);
      #1;
      write = 1'b0;
      #1;
      check($sformatf("v%0d_pred_after", i), 32'(prediction), 32'(vecs[i].pred_after));
      check($sformatf("v%0d_upd", i), 32'(update_count), 32'(vecs[i].upd));
      check($sformatf("v%0d_mis", i), 32'(mispredict_count), 32'(vecs[i].mis));
    end
    read_pc = 32'h100;
    #1;
    check("trained_pred_100", 32'(prediction), 32'd1);

    // Clear with a simultaneous update: clear wins
    @(posedge clk);
    #1;
    read_pc     = 32'h204;
    write_pc    = 32'h204;
    write_value = 1'b1;
    write       = 1'b1;
    clear       = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    write_value = 1'b0;
    #1;
    check("clr_ready", 32'(ready), 32'd0);
    check("clr_upd", 32'(update_count), 32'd0);
    check("clr_mis", 32'(mispredict_count), 32'd0);
    check("clr_pred", 32'(prediction), 32'd1);
    check("clr_corr_follows_wv", 32'(is_correct), 32'd0);
    @(posedge clk);
    #1;
    write = 1'b0;
    #1;
    check("sweep_write_ignored_upd", 32'(update_count), 32'd0);
    wait_ready("clear_sweep_len", 255);
    #1;
    check("post_clear_pred_204", 32'(prediction), 32'd1);
    check("post_clear_upd", 32'(update_count), 32'd0);

    // One accepted update, then reset in the middle of another
    @(posedge clk);
    #1;
    write_pc    = 32'h100;
    write_value = 1'b1;
    write       = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_upd", 32'(update_count), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_upd_rst_ready", 32'(ready), 32'd0);
    check("mid_upd_rst_upd", 32'(update_count), 32'd0);
    check("mid_upd_rst_pred", 32'(prediction), 32'd1);
    @(posedge clk);
    #1;
    write = 1'b0;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("mid_sweep_ready", 32'(ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_sweep_rst_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready("rst_resweep_len", 256);
    check("final_upd", 32'(update_count), 32'd0);
    check("final_mis", 32'(mispredict_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/local_predictor_param.md
Name: local_predictor_param

Overview:
- Parametrised second-generation two-level local branch predictor for the mp3 pipeline fetch stage.
- Per-PC branch history table (BHT) selects a saturating counter in a pattern history table (PHT).
- Adds configurable table depths, history length and counter width.
- Adds a hardware table-initialisation sweep after reset or clear, a ready flag, and saturating accuracy statistics.

Parameters:
- BHT_IDX_BITS, 8: log2 BHT entries; BHT index = pc[BHT_IDX_BITS+1:2].
- HIST_BITS, 2: local history length per BHT entry; must be ≥1.
- PHT_IDX_BITS, 8: log2 PHT entries; must be > HIST_BITS.
- CTR_BITS, 2: PHT counter width; must be ≥2.
- STAT_BITS, 16: width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous request to restart the initialisation sweep.
- ready  out  1  tables valid; low during the sweep.
- read_pc  in  32  fetch PC to predict.
- prediction  out  1  predicted direction (1 = taken).
- write_pc  in  32  PC of the resolved branch.
- write  in  1  update strobe.
- write_value  in  1  resolved direction.
- is_correct  out  1  write_value equals the current PHT prediction for write_pc.
- update_count  out  STAT_BITS  accepted updates, saturating.
- mispredict_count  out  STAT_BITS  accepted updates with is_correct = 0, saturating.

Behaviour:
- Index rules:
  - bht_idx = pc[BHT_IDX_BITS+1:2].
  - pht_idx = {pc[PHT_IDX_BITS-HIST_BITS+1:2], history}, with history in the low bits.
  - Read and write paths compute these independently.
- Counters:
  - CTR_BITS-wide unsigned.
  - Init value WT = 1 << (CTR_BITS-1).
  - prediction = MSB of the counter.
- Reset (rst_n = 0, asynchronous) forces:
  - state = INIT, sweep index = 0.
  - ready = 0.
  - update_count = 0, mispredict_count = 0.
  - Table contents are undefined until the sweep completes.
- FSM has two states:
  - INIT:
    - Each cycle writes BHT[i] = 0 (if i < 2^BHT_IDX_BITS) and PHT[i] = WT (if i < 2^PHT_IDX_BITS).
    - i increments by 1 per cycle.
    - The state lasts max(2^BHT_IDX_BITS, 2^PHT_IDX_BITS) cycles, then moves to RUN.
    - ready goes high on the first RUN cycle.
  - RUN:
    - Normal operation.
    - clear = 1 on any clock edge returns the FSM to INIT with i = 0 and zeroes both stats counters.
    - clear asserted during INIT restarts the sweep at 0.
- While ready = 0:
  - prediction = 1 (weakly taken default).
  - is_correct = write_value.
  - write is ignored: no table or stats update.
- Prediction and is_correct are combinational from the arrays: zero-cycle latency.
- Update on posedge clk when write = 1 and state is RUN:
  - BHT[w_bht] <= {write_value, history[HIST_BITS-1:1]}; the MSB holds the most recent outcome.
  - PHT[w_pht] increments if write_value = 1 and it is not all-ones.
  - PHT[w_pht] decrements if write_value = 0 and it is not zero.
  - Both updates use pre-update contents.
- Stats, on an accepted update:
  - update_count += 1.
  - mispredict_count += 1 if !is_correct.
  - Both hold at 2^STAT_BITS-1.
- Same-cycle read and write of the same entries: the read sees old contents (no bypass). The new value is visible the next cycle.
- Update and clear in the same cycle: clear wins. The update is dropped and the stats are zeroed.

Test Plan:
- Reset, defaults:
  - Release rst_n; ready must stay 0 for exactly 256 cycles, then rise.
  - prediction = 1 for every read_pc, both before and after ready.
- Train taken, read_pc = write_pc = 0x100:
  - First write_value = 1: is_correct = 1 before the edge; PHT[0] 10→11; BHT[0x40] = 2'b10.
  - Second write_value = 1: PHT[2] 10→11; BHT[0x40] = 2'b11.
  - Afterwards prediction(0x100) = 1; update_count = 2, mispredict_count = 0.
- Train not-taken, PC 0x204:
  - First write_value = 0: is_correct = 0, PHT[4] 10→01, mispredict_count = 1.
  - Second write_value = 0: is_correct = 1, PHT[4] → 00.
  - Third write_value = 0: PHT[4] stays 00.
  - prediction(0x204) = 0.
- Write with read_pc = write_pc = 0x204 in the same cycle: prediction shows the old counter during that cycle and the new one the next cycle.
- Assert clear in RUN after training:
  - ready = 0 for 256 cycles and stats = 0.
  - A write issued during the sweep changes nothing.
  - After ready, prediction(0x204) = 1.
- Pulse rst_n low mid-sweep (cycle 100) and mid-update:
  - Outputs reset immediately.
  - The sweep restarts and ready rises 256 cycles after release.
- With STAT_BITS = 4: issue 20 mispredicting updates → mispredict_count = 15 and update_count = 15.
